// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier instead.
module muldiv_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   f3,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         stall,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N + 1);

  // Handshake: an operation is taken on a rising edge where the unit is IDLE, start=1 and
  // flush=0; stall holds the pipeline from that cycle through CALC, and done marks the single
  // cycle in which result carries the new value.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [2:0]    op_q;
  logic          neg_q, neg_r_q, busy_q;
  logic [N-1:0]  hi_q, lo_q, opnd_q, pend_q, result_q;
  logic [CW-1:0] cnt_q;

  logic          is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [N-1:0]  a_mag, b_mag;
  logic          div_zero, div_ovf, special, fast;
  logic [N-1:0]  special_res;

  assign is_div   = f3[2];
  assign a_sgn    = is_div ? ~f3[0] : (f3[1:0] != 2'b11);
  assign b_sgn    = is_div ? ~f3[0] : ~f3[1];
  assign a_neg    = a_sgn & a[N-1];
  assign b_neg    = b_sgn & b[N-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = is_div && !f3[0] && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
  assign special  = div_zero || div_ovf;
  // f3[1] selects the remainder variants of the divide group
  assign special_res = div_zero ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*N-1:0] fast_prod;
  assign fast_prod = {{N{1'b0}}, a_mag} * {{N{1'b0}}, b_mag};
  assign fast      = ~is_div;
`else
  assign fast = 1'b0;
`endif

  // One iteration of either datapath; hi/lo hold accumulator or remainder/quotient.
  logic [N:0]   add_sum, shifted;
  logic [N-1:0] diff, iter_hi, iter_lo;
  logic         div_ge;

  assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign shifted = {hi_q, lo_q[N-1]};
  assign div_ge  = shifted >= {1'b0, opnd_q};
  assign diff    = shifted[N-1:0] - opnd_q;
  assign iter_hi = op_q[2] ? (div_ge ? diff : shifted[N-1:0]) : add_sum[N:1];
  assign iter_lo = op_q[2] ? {lo_q[N-2:0], div_ge} : {add_sum[0], lo_q[N-1:1]};

  function automatic logic [N-1:0] finish_op(input logic [2:0] op, input logic neg_p,
                                             input logic neg_r, input logic [N-1:0] hi,
                                             input logic [N-1:0] lo);
    logic [2*N-1:0] p;
    logic [N-1:0]   res;
    p = neg_p ? -{hi, lo} : {hi, lo};
    if (op[2]) res = op[1] ? (neg_r ? -hi : hi) : (neg_p ? -lo : lo);
    else       res = (op[1:0] == 2'b00) ? p[N-1:0] : p[2*N-1:N];
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && !flush) state_nx = (special || fast) ? DONE : CALC;
      CALC: begin
        if (flush)                state_nx = IDLE;
        else if (cnt_q == CW'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall  = ((state == IDLE) && start && !flush && !rst) || (state == CALC);
    done   = (state == DONE) && !flush && !rst;
    busy   = busy_q;
    result = done ? pend_q : result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          op_q    <= f3;
          neg_q   <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          hi_q    <= '0;
          lo_q    <= is_div ? a_mag : b_mag;
          opnd_q  <= is_div ? b_mag : a_mag;
          cnt_q   <= CW'(N);
          if (special) pend_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
          else if (fast) pend_q <= finish_op(f3, a_neg ^ b_neg, a_neg,
                                             fast_prod[2*N-1:N], fast_prod[N-1:0]);
`endif
        end
        CALC: if (!flush) begin
          hi_q  <= iter_hi;
          lo_q  <= iter_lo;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) pend_q <= finish_op(op_q, neg_q, neg_r_q, iter_hi, iter_lo);
        end
        DONE: if (!flush) result_q <= pend_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops against a reference
// model, and hand-written flush / reset / ignored-start sequences.
module tb_muldiv_sequencer;
  localparam int N = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = N + 1;
`endif
  localparam int DL = N + 1;

  logic         clk, rst, start, flush;
  logic [2:0]   f3;
  logic [N-1:0] a, b;
  logic         busy, stall, done;
  logic [N-1:0] result;

  muldiv_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .f3(f3), .a(a), .b(b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [N-1:0] last_res = '0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] exp;
    int           lat;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h expected=none t=%0t", result, $time);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        chk("result", result, e);
        last_res = e;
      end
    end
  end

  function automatic logic [N-1:0] model(input logic [2:0] op, input logic [N-1:0] x,
                                         input logic [N-1:0] y);
    logic signed [2*N-1:0] sx, sy, uy, p;
    logic signed [N-1:0]   qx, qy;
    logic [N-1:0]          r;
    sx = {{N{x[N-1]}}, x};
    sy = {{N{y[N-1]}}, y};
    uy = {{N{1'b0}}, y};
    qx = x;
    qy = y;
    r  = '0;
    case (op)
      3'd0: begin p = sx * sy;                  r = p[N-1:0];   end
      3'd1: begin p = sx * sy;                  r = p[2*N-1:N]; end
      3'd2: begin p = sx * uy;                  r = p[2*N-1:N]; end
      3'd3: begin p = {{N{1'b0}}, x} * uy;      r = p[2*N-1:N]; end
      3'd4: r = (y == 0) ? '1 : ((x == 32'h80000000 && y == '1) ? x : N'(qx / qy));
      3'd5: r = (y == 0) ? '1 : x / y;
      3'd6: r = (y == 0) ? x : ((x == 32'h80000000 && y == '1) ? '0 : N'(qx % qy));
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // driver: present one op, track stall through to done, optionally pulse start at poke_at
  task automatic run_op(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] exp, input int lat, input int poke_at);
    bit got;
    f3 = op; a = x; b = y; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    chk("stall_at_start", stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int k = 1; k <= N + 5 && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        chk("latency", k, lat);
        chk("stall_in_done", stall, 0);
      end else begin
        chk("stall_in_calc", stall, 1);
      end
      if (k == poke_at) begin
        start = 1'b1; f3 = ~op; a = ~x; b = x;
      end else begin
        start = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none expected=done op=%0d t=%0t", op, $time);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int dc;
    logic [2:0]   op;
    logic [N-1:0] x, y;
    int           lat;

    vt[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, ML};
    vt[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
    vt[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML};
    vt[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML};
    vt[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DL};
    vt[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DL};
    vt[6]  = '{3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, DL};
    vt[7]  = '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    vt[8]  = '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1};
    vt[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vt[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vt[11] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1};
    vt[12] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, ML};
    vt[13] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ML};
    vt[14] = '{3'd4, 32'h80000000, 32'h00000003, 32'hD5555556, DL};
    vt[15] = '{3'd6, 32'h80000000, 32'h00000003, 32'hFFFFFFFE, DL};
    vt[16] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DL};
    vt[17] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, DL};
    vt[18] = '{3'd7, 32'h80000000, 32'h00000003, 32'h00000002, DL};
    vt[19] = '{3'd3, 32'h80000000, 32'h00000002, 32'h00000001, ML};

    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++)
      run_op(vt[i].op, vt[i].x, vt[i].y, vt[i].exp, vt[i].lat, -1);

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom();
      y  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom());
      if (!op[2])
        lat = ML;
      else if (y == 0 || (!op[0] && x == 32'h80000000 && y == '1))
        lat = 1;
      else
        lat = DL;
      run_op(op, x, y, model(op, x, y), lat, -1);
    end

    // flush in CALC cycle 10: no done, result held, unit idle next cycle
    f3 = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_stall", stall, 0);
    chk("flush_result", result, last_res);
    dc = done_cnt;
    repeat (N + 4) @(negedge clk);
    chk("flush_no_done", done_cnt, dc);
    @(posedge clk); #1;
    run_op(3'd5, 32'd100, 32'd7, 32'd14, DL, -1);

    // flush together with start in IDLE drops the request
    f3 = 3'd4; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", stall, 0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", busy, 0);
    @(posedge clk); #1;

    // start pulsed mid-CALC, then start asserted in DONE: both ignored
    run_op(3'd7, 32'd100, 32'd7, 32'd2, DL, 12);
    run_op(3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, DL, DL);

    // synchronous reset mid-CALC
    f3 = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    dc = done_cnt;
    repeat (N + 4) @(negedge clk);
    chk("rst_no_done", done_cnt, dc);
    @(posedge clk); #1;
    run_op(3'd0, 32'd12345, 32'd678, 32'd8369910, ML, -1);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
